stream_demux_1ton: RTL and testbench

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshake and packet-atomic routing. It is the successor of the 1-to-2 combinational demux. The destination is taken from sel_in (MODE 0) or an internal round-robin pointer (MODE 1). The chosen destination is locked for the whole packet, so a packet is never split across outputs. It sits between a single producer stream and N consumer channels in the lab datapath.

---
 rtl/stream_demux_1ton.sv | 113 +++++++++++
 tb/tb_stream_demux_1ton.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-N valid/ready demux with packet-atomic routing
// and drop-on-invalid-select; one holding register per output channel.
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel_in,
    output logic [N_OUT*DATA_W-1:0]   out_data,
    output logic [N_OUT-1:0]          out_valid,
    output logic [N_OUT-1:0]          out_last,
    input  logic [N_OUT-1:0]          out_ready,
    output logic [7:0]                drop_cnt,
    output logic                      busy
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          lock_ch_q, lock_ch_d;
    logic                      drop_q, drop_d;
    logic [SEL_W-1:0]          rr_q, rr_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [N_OUT-1:0]          vld_q, vld_d;
    logic [N_OUT-1:0]          last_q, last_d;
    logic [N_OUT*DATA_W-1:0]   data_q, data_d;

    logic [SEL_W-1:0]          tgt;
    logic                      drop;
    logic [N_OUT-1:0]          tgt_oh;
    logic                      acc;
    logic                      wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            drop_q    <= 1'b0;
            rr_q      <= '0;
            cnt_q     <= '0;
            vld_q     <= '0;
            last_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            drop_q    <= drop_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            data_q    <= data_d;
        end
    end

    // An out-of-range target decodes to an all-zero one-hot, so it never looks full.
    always_comb begin
        tgt    = (state_q == LOCKED) ? lock_ch_q : ((MODE == 1) ? rr_q : sel_in);
        drop   = (state_q == LOCKED) ? drop_q
                                     : ((MODE == 0) && ({1'b0, sel_in} >= (SEL_W+1)'(N_OUT)));
        tgt_oh = '0;
        for (int k = 0; k < N_OUT; k++)
            tgt_oh[k] = (tgt == SEL_W'(k));
        acc = in_valid & in_ready;
        wr  = acc & ~drop;
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        drop_d    = drop_q;
        if (state_q == IDLE && acc && !in_last) begin
            state_d   = LOCKED;
            lock_ch_d = tgt;
            drop_d    = drop;
        end else if (state_q == LOCKED && acc && in_last) begin
            state_d = IDLE;
            drop_d  = 1'b0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (MODE == 1 && acc && in_last)
            rr_d = (rr_q == SEL_W'(N_OUT-1)) ? '0 : rr_q + 1'b1;
        cnt_d = (acc && drop && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
        vld_d  = vld_q;
        last_d = last_q;
        data_d = data_q;
        for (int k = 0; k < N_OUT; k++) begin
            vld_d[k] = (wr & tgt_oh[k]) | (vld_q[k] & ~out_ready[k]);
            if (wr && tgt_oh[k]) begin
                last_d[k]                    = in_last;
                data_d[k*DATA_W +: DATA_W]   = in_data;
            end
        end
    end

    always_comb begin
        in_ready  = ~rst & ~|(tgt_oh & vld_q & ~out_ready);
        busy      = (state_q == LOCKED);
        out_valid = vld_q;
        out_last  = last_q;
        out_data  = data_q;
        drop_cnt  = cnt_q;
    end
endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb_stream_demux_1ton: checks a select-driven and a round-robin instance against
// a packet-level scoreboard plus directed scenario checks.
module tb_stream_demux_1ton;
    logic        clk;
    logic        rst;
    logic [7:0]  in_data [2];
    logic [1:0]  in_valid, in_last, in_ready, busy;
    logic [2:0]  sel0;
    logic [1:0]  sel1;
    logic [31:0] out_data [2];
    logic [3:0]  out_valid [2];
    logic [3:0]  out_last [2];
    logic [3:0]  out_ready [2];
    logic [7:0]  drop_cnt [2];

    int n_assert = 0;
    int n_fail   = 0;
    bit rnd      = 0;

    // scoreboard: one expected entry per channel, packet state per instance
    bit         m_v [2][4];
    logic [7:0] m_d [2][4];
    bit         m_l [2][4];
    bit         m_pkt [2];
    int         m_dest [2];
    int         m_cnt [2];
    int         m_drop [2];

    stream_demux_1ton #(.DATA_W(8), .N_OUT(4), .SEL_W(3), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_last(in_last[0]), .in_ready(in_ready[0]), .sel_in(sel0),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]),
        .out_ready(out_ready[0]), .drop_cnt(drop_cnt[0]), .busy(busy[0]));

    stream_demux_1ton #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_last(in_last[1]), .in_ready(in_ready[1]), .sel_in(sel1),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]),
        .out_ready(out_ready[1]), .drop_cnt(drop_cnt[1]), .busy(busy[1]));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Predict what the coming rising edge does, after checking present outputs.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int dest;
            bit dropping, exp_rdy;
            int exp_drop;
            if (rst) begin
                n_assert++;
                if (in_ready[i] !== 1'b0 || out_valid[i] !== 4'b0 || busy[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_hold inst%0d: in_ready=%b out_valid=%b busy=%b, want all 0",
                             i, in_ready[i], out_valid[i], busy[i]);
                end
                for (int k = 0; k < 4; k++) m_v[i][k] = 0;
                m_pkt[i]  = 0;
                m_cnt[i]  = 0;
                m_drop[i] = 0;
            end else begin
                dest     = m_pkt[i] ? m_dest[i] : ((i == 0) ? int'(sel0) : m_cnt[i] % 4);
                dropping = (dest >= 4);
                exp_rdy  = dropping ? 1'b1 : (!m_v[i][dest] || out_ready[i][dest]);
                exp_drop = (m_drop[i] > 255) ? 255 : m_drop[i];
                n_assert += 3;
                if (in_ready[i] !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL sb_in_ready inst%0d t=%0t: got %b want %b", i, $time, in_ready[i], exp_rdy);
                end
                if (busy[i] !== m_pkt[i]) begin
                    n_fail++;
                    $display("FAIL sb_busy inst%0d t=%0t: got %b want %b", i, $time, busy[i], m_pkt[i]);
                end
                if (drop_cnt[i] !== 8'(exp_drop)) begin
                    n_fail++;
                    $display("FAIL sb_drop_cnt inst%0d t=%0t: got %0d want %0d", i, $time, drop_cnt[i], exp_drop);
                end
                for (int k = 0; k < 4; k++) begin
                    n_assert++;
                    if (out_valid[i][k] !== m_v[i][k]) begin
                        n_fail++;
                        $display("FAIL sb_valid inst%0d ch%0d t=%0t: got %b want %b", i, k, $time, out_valid[i][k], m_v[i][k]);
                    end else if (m_v[i][k] && (out_data[i][k*8 +: 8] !== m_d[i][k] || out_last[i][k] !== m_l[i][k])) begin
                        n_fail++;
                        $display("FAIL sb_beat inst%0d ch%0d t=%0t: got %h/%b want %h/%b", i, k, $time,
                                 out_data[i][k*8 +: 8], out_last[i][k], m_d[i][k], m_l[i][k]);
                    end
                end
                for (int k = 0; k < 4; k++)
                    if (m_v[i][k] && out_ready[i][k]) m_v[i][k] = 0;
                if (in_valid[i] && exp_rdy) begin
                    if (dropping) m_drop[i]++;
                    else begin
                        m_v[i][dest] = 1;
                        m_d[i][dest] = in_data[i];
                        m_l[i][dest] = in_last[i];
                    end
                    if (in_last[i]) begin
                        m_pkt[i] = 0;
                        m_cnt[i]++;
                    end else if (!m_pkt[i]) begin
                        m_pkt[i]  = 1;
                        m_dest[i] = dest;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) begin
            out_ready[0] = 4'($urandom);
            out_ready[1] = 4'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit l, input int s, output int waited);
        bit ok;
        in_valid[i] = 1;
        in_data[i]  = d;
        in_last[i]  = l;
        if (i == 0) sel0 = 3'(s); else sel1 = 2'(s);
        waited = 0;
        do begin
            @(negedge clk);
            ok = in_ready[i];
            step();
            waited++;
        end while (!ok && waited < 100);
        in_valid[i] = 0;
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_timeout inst%0d: beat %h not accepted in %0d cycles", i, d, waited);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        in_valid = 0; in_last = 0; in_data[0] = 0; in_data[1] = 0;
        sel0 = 0; sel1 = 0;
        out_ready[0] = 4'hf; out_ready[1] = 4'hf;
        #2;
        for (int i = 0; i < 2; i++) begin
            n_assert += 2;
            if (out_data[i] !== 32'h0 || out_last[i] !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_data inst%0d: data=%h last=%b want 0", i, out_data[i], out_last[i]);
            end
            if (drop_cnt[i] !== 8'd0 || in_ready[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctl inst%0d: drop_cnt=%0d in_ready=%b want 0", i, drop_cnt[i], in_ready[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_single();
        int w;
        idle(1);
        send(0, 8'hA5, 1, 2, w);
        n_assert++;
        if (out_valid[0] !== 4'b0100 || out_last[0] !== 4'b0100 || out_data[0][23:16] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_beat: valid=%b last=%b ch2=%h want 0100/0100/a5",
                     out_valid[0], out_last[0], out_data[0][23:16]);
        end
    endtask

    task automatic test_locked();
        int w;
        logic [7:0] beats [3] = '{8'h11, 8'h22, 8'h33};
        idle(2);
        for (int b = 0; b < 3; b++) begin
            send(0, beats[b], b == 2, (b == 0) ? 1 : 3, w);
            n_assert++;
            if (out_valid[0] !== 4'b0010 || out_data[0][15:8] !== beats[b] || busy[0] !== (b != 2)) begin
                n_fail++;
                $display("FAIL locked_beat%0d: valid=%b ch1=%h busy=%b want 0010/%h/%b",
                         b, out_valid[0], out_data[0][15:8], busy[0], beats[b], b != 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        idle(2);
        out_ready[0] = 4'b1110;
        send(0, 8'h44, 0, 0, w);
        in_valid[0] = 1; in_data[0] = 8'h55; in_last[0] = 1;
        repeat (3) begin
            @(negedge clk);
            n_assert++;
            if (in_ready[0] !== 1'b0 || out_valid[0][0] !== 1'b1 || out_data[0][7:0] !== 8'h44) begin
                n_fail++;
                $display("FAIL bp_hold: in_ready=%b v0=%b d0=%h want 0/1/44", in_ready[0], out_valid[0][0], out_data[0][7:0]);
            end
        end
        @(posedge clk);
        #1 out_ready[0] = 4'hf;
        @(negedge clk);
        n_assert++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b want 1", in_ready[0]);
        end
        @(posedge clk);
        #1 in_valid[0] = 0;
        n_assert++;
        if (out_valid[0] !== 4'b0001 || out_data[0][7:0] !== 8'h55 || out_last[0][0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second: valid=%b d0=%h last0=%b busy=%b want 0001/55/1/0",
                     out_valid[0], out_data[0][7:0], out_last[0][0], busy[0]);
        end
        step();
        n_assert++;
        if (out_valid[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_drained: valid=%b want 0000", out_valid[0]);
        end
    endtask

    task automatic test_round_robin();
        int w;
        idle(1);
        for (int p = 0; p < 5; p++) begin
            send(1, 8'(p + 1), 1, 3, w);
            n_assert++;
            if (out_valid[1] !== 4'(1 << (p % 4)) || out_data[1][(p%4)*8 +: 8] !== 8'(p + 1)) begin
                n_fail++;
                $display("FAIL rr_pkt%0d: valid=%b data=%h want %b/%h", p, out_valid[1],
                         out_data[1][(p%4)*8 +: 8], 4'(1 << (p % 4)), 8'(p + 1));
            end
        end
    endtask

    task automatic test_drop();
        int w;
        idle(2);
        send(0, 8'hAA, 0, 5, w);
        n_assert++;
        if (w != 1 || out_valid[0] !== 4'b0 || busy[0] !== 1'b1 || drop_cnt[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL drop_first: wait=%0d valid=%b busy=%b cnt=%0d want 1/0000/1/1", w, out_valid[0], busy[0], drop_cnt[0]);
        end
        send(0, 8'hBB, 1, 0, w);
        n_assert++;
        if (w != 1 || out_valid[0] !== 4'b0 || busy[0] !== 1'b0 || drop_cnt[0] !== 8'd2) begin
            n_fail++;
            $display("FAIL drop_second: wait=%0d valid=%b busy=%b cnt=%0d want 1/0000/0/2", w, out_valid[0], busy[0], drop_cnt[0]);
        end
        for (int j = 0; j < 300; j++) send(0, 8'($urandom), j == 299, 5, w);
        n_assert++;
        if (drop_cnt[0] !== 8'd255 || out_valid[0] !== 4'b0) begin
            n_fail++;
            $display("FAIL drop_saturate: cnt=%0d valid=%b want 255/0000", drop_cnt[0], out_valid[0]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        rnd = 1;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 40; p++) begin
                int len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    send(i, 8'($urandom), b == len - 1, (b == 0) ? $urandom_range(0, 4) : $urandom_range(0, 7), w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
            end
        rnd = 0;
        out_ready[0] = 4'hf; out_ready[1] = 4'hf;
        idle(3);
        n_assert++;
        if (out_valid[0] !== 4'b0 || out_valid[1] !== 4'b0) begin
            n_fail++;
            $display("FAIL random_drain: valid0=%b valid1=%b want 0000", out_valid[0], out_valid[1]);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        idle(2);
        out_ready[0] = 4'b1101;
        send(0, 8'h66, 0, 1, w);
        n_assert++;
        if (out_valid[0] !== 4'b0010 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup: valid=%b busy=%b want 0010/1", out_valid[0], busy[0]);
        end
        #3 rst = 1;
        #1;
        n_assert++;
        if (out_valid[0] !== 4'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0 || out_data[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: valid=%b busy=%b in_ready=%b data=%h want all 0",
                     out_valid[0], busy[0], in_ready[0], out_data[0]);
        end
        @(posedge clk);
        #1 rst = 0;
        out_ready[0] = 4'hf;
        send(0, 8'h77, 1, 0, w);
        n_assert++;
        if (out_valid[0] !== 4'b0001 || out_data[0][7:0] !== 8'h77 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: valid=%b d0=%h busy=%b want 0001/77/0", out_valid[0], out_data[0][7:0], busy[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_locked();
        test_backpressure();
        test_round_robin();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
